// File: rtl/matrix_frame_serializer_if.sv
// Serializer link bundle: frame control, pc_matrix address, board memory
// and the bit-serial Arduino side.
interface matrix_frame_serializer_if #(
  parameter int WORD_W = 16
);
  logic              start;
  logic [15:0]       addr;
  logic [WORD_W-1:0] mem_data;
  logic              arduino_ack;
  logic              pc_advance;
  logic              ser_clk;
  logic              ser_data;
  logic              word_valid;
  logic              frame_done;
  logic              busy;

  modport master (
    output start, addr, mem_data, arduino_ack,
    input  pc_advance, ser_clk, ser_data,
    input  word_valid, frame_done, busy
  );

  modport slave (
    input  start, addr, mem_data, arduino_ack,
    output pc_advance, ser_clk, ser_data,
    output word_valid, frame_done, busy
  );
endinterface

// File: rtl/matrix_frame_serializer.sv
// Walks the board memory one address per word, shifts each word MSB-first
// to the Arduino, and advances pc_matrix after a four-phase word handshake.
module matrix_frame_serializer #(
  parameter int          CLK_DIV     = 4,
  parameter int          MEM_LATENCY = 1,
  parameter logic [15:0] MAX_ADDR    = 16'h00FF,
  parameter int          WORD_W      = 16
) (
  input logic                     clk,
  input logic                     reset_arduino,
  matrix_frame_serializer_if.slave bus
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [7:0] DIV_END = 8'(CLK_DIV - 1);
  localparam logic [2:0] LAT_END =
    3'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SHIFT,
    HANDSHAKE, RELEASE, ADVANCE, DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [BW-1:0]     bit_cnt;
  logic [7:0]        div_cnt;
  logic [2:0]        lat_cnt;
  logic              last;
  logic              ack_meta;
  logic              ack_s;
  logic              pc_advance;
  logic              ser_clk;
  logic              ser_data;
  logic              word_valid;
  logic              frame_done;
  logic              busy;

  always_ff @(posedge clk or negedge reset_arduino) begin
    if (!reset_arduino) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      lat_cnt    <= '0;
      last       <= 1'b0;
      ack_meta   <= 1'b0;
      ack_s      <= 1'b0;
      pc_advance <= 1'b0;
      ser_clk    <= 1'b0;
      ser_data   <= 1'b0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack_meta <= bus.arduino_ack;
      ack_s    <= ack_meta;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            lat_cnt <= '0;
          end
        end
        FETCH: begin
          if (MEM_LATENCY == 0 || lat_cnt == LAT_END)
            state <= LOAD;
          else
            lat_cnt <= lat_cnt + 3'd1;
        end
        LOAD: begin
          sreg     <= bus.mem_data;
          last     <= (bus.addr == MAX_ADDR);
          bit_cnt  <= BW'(WORD_W);
          div_cnt  <= '0;
          ser_clk  <= 1'b0;
          ser_data <= bus.mem_data[WORD_W-1];
          state    <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_END) begin
            div_cnt <= '0;
            if (!ser_clk) begin
              ser_clk <= 1'b1;
            end else begin
              // Data only moves on the falling edge of ser_clk.
              ser_clk <= 1'b0;
              sreg    <= sreg << 1;
              bit_cnt <= bit_cnt - BW'(1);
              if (bit_cnt == BW'(1)) begin
                ser_data   <= 1'b0;
                word_valid <= 1'b1;
                state      <= HANDSHAKE;
              end else begin
                ser_data <= sreg[WORD_W-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HANDSHAKE: begin
          if (ack_s) begin
            word_valid <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            pc_advance <= 1'b1;
            state      <= ADVANCE;
          end
        end
        ADVANCE: begin
          pc_advance <= 1'b0;
          if (last) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            lat_cnt <= '0;
            state   <= FETCH;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc_advance = pc_advance;
  assign bus.ser_clk    = ser_clk;
  assign bus.ser_data   = ser_data;
  assign bus.word_valid = word_valid;
  assign bus.frame_done = frame_done;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_matrix_frame_serializer.sv
// Scoreboard bench: shifted words are checked against a queue of expected
// words; pc_matrix and the board memory are modelled here.
module tb_matrix_frame_serializer;

  logic clk;
  logic rst_n;

  matrix_frame_serializer_if #(.WORD_W(16)) bus();

  matrix_frame_serializer #(
    .CLK_DIV(1),
    .MEM_LATENCY(1),
    .MAX_ADDR(16'h0003),
    .WORD_W(16)
  ) dut (
    .clk(clk),
    .reset_arduino(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];
  logic [15:0] shreg = '0;
  int nbits = 0;
  int sclk_cnt = 0;
  int adv_cnt = 0;
  int fd_cnt = 0;
  int fd_adv = 0;
  int wv_age = 0;
  bit auto_ack = 1;
  bit ovr_en = 0;
  logic [15:0] ovr_val = '0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // pc_matrix model, sharing the reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.addr <= '0;
    else if (bus.pc_advance)
      bus.addr <= (bus.addr == 16'd3) ? 16'd0 : bus.addr + 16'd1;
  end

  assign bus.mem_data = ovr_en ? ovr_val : bus.addr * 16'h1111;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  initial forever begin
    @(posedge bus.ser_clk or negedge rst_n);
    if (!rst_n) begin
      nbits = 0;
    end else begin
      shreg = {shreg[14:0], bus.ser_data};
      nbits++;
      sclk_cnt++;
    end
  end

  initial forever begin
    @(posedge bus.word_valid);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_word: got %0h expected none", shreg);
    end else begin
      chk("word", {16'h0, shreg}, {16'h0, exp_q.pop_front()});
      chk("word_bits", nbits, 16);
    end
    nbits = 0;
  end

  initial forever begin
    @(posedge bus.pc_advance);
    adv_cnt++;
  end

  initial forever begin
    @(posedge bus.frame_done);
    fd_cnt++;
    fd_adv = adv_cnt;
  end

  initial forever begin
    @(negedge clk);
    if (auto_ack) begin
      if (bus.word_valid) begin
        wv_age++;
        if (wv_age >= 3) bus.arduino_ack = 1'b1;
      end else begin
        wv_age = 0;
        bus.arduino_ack = 1'b0;
      end
    end
  end

  task automatic wait_adv(int target, int budget, string name);
    int n = 0;
    while (adv_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, adv_cnt >= target, 1);
  endtask

  task automatic wait_fd(int target, int budget, string name);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, fd_cnt >= target, 1);
  endtask

  task automatic wait_wv(logic lvl, int budget, string name);
    int n = 0;
    while (bus.word_valid !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.word_valid, lvl);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic logic [5:0] outs();
    return {bus.pc_advance, bus.ser_clk, bus.ser_data,
            bus.word_valid, bus.frame_done, bus.busy};
  endfunction

  initial begin
    int a0, a1, s0, f0, viol;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.arduino_ack = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 6'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    // full frame, start pulsed once
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    pulse_start();
    wait_fd(1, 800, "frame1_done");
    chk("frame1_adv", fd_adv, 4);
    @(negedge clk);
    chk("frame1_busy", bus.busy, 0);
    chk("frame1_addr", bus.addr, 0);
    chk("frame1_fd_cnt", fd_cnt, 1);

    // single word A5C3
    ovr_val = 16'hA5C3;
    ovr_en = 1;
    exp_q.push_back(16'hA5C3);
    s0 = sclk_cnt;
    pulse_start();
    wait_adv(5, 200, "single_adv");
    chk("single_sclk", sclk_cnt - s0, 16);
    ovr_en = 0;
    auto_ack = 0;
    exp_q.push_back(16'h1111);
    @(negedge clk);
    chk("single_addr", bus.addr, 1);

    // ack held low for 1000 cycles
    wait_wv(1, 200, "stall_wv_rise");
    a0 = adv_cnt;
    s0 = sclk_cnt;
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!bus.word_valid) viol++;
    end
    chk("stall_wv_held", viol, 0);
    chk("stall_no_adv", adv_cnt, a0);
    chk("stall_no_sclk", sclk_cnt, s0);

    // ack high: RELEASE blocks until it falls
    exp_q.push_back(16'h2222);
    bus.arduino_ack = 1'b1;
    wait_wv(0, 10, "rel_wv_fall");
    repeat (50) @(negedge clk);
    chk("rel_no_adv", adv_cnt, a0);
    chk("rel_busy", bus.busy, 1);
    bus.arduino_ack = 1'b0;
    wait_adv(a0 + 1, 10, "rel_adv");

    // ack already high before HANDSHAKE
    bus.arduino_ack = 1'b1;
    wait_wv(1, 100, "pre_wv_rise");
    wait_wv(0, 5, "pre_wv_fall");
    a1 = adv_cnt;
    repeat (50) @(negedge clk);
    chk("pre_no_adv", adv_cnt, a1);
    bus.arduino_ack = 1'b0;
    wait_adv(a1 + 1, 10, "pre_adv");
    @(negedge clk);
    chk("pre_addr", bus.addr, 3);

    // last word closes the frame
    exp_q.push_back(16'h3333);
    auto_ack = 1;
    f0 = fd_cnt;
    wait_fd(f0 + 1, 200, "frame2_done");
    chk("frame2_adv", fd_adv, a1 + 2);
    @(negedge clk);
    chk("frame2_busy", bus.busy, 0);
    chk("frame2_addr", bus.addr, 0);

    // back-to-back frames with start held high
    for (int r = 0; r < 2; r++)
      for (int w = 0; w < 4; w++)
        exp_q.push_back(16'(w) * 16'h1111);
    a0 = adv_cnt;
    f0 = fd_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    wait_fd(f0 + 1, 800, "b2b_first_done");
    @(negedge clk);
    chk("b2b_idle_gap", bus.busy, 0);
    @(negedge clk);
    chk("b2b_restart", bus.busy, 1);
    wait_fd(f0 + 2, 800, "b2b_second_done");
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_stopped", bus.busy, 0);
    chk("b2b_adv", adv_cnt - a0, 8);
    chk("b2b_queue", exp_q.size(), 0);

    // reset in the middle of a word
    ovr_val = 16'h5A5A;
    ovr_en = 1;
    exp_q.push_back(16'h5A5A);
    s0 = sclk_cnt;
    pulse_start();
    for (int n = 0; n < 100 && sclk_cnt < s0 + 5; n++)
      @(negedge clk);
    chk("mid_bits", sclk_cnt - s0, 5);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset_outs", outs(), 6'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_idle", outs(), 6'b0);
    a0 = adv_cnt;
    exp_q.push_back(16'h5A5A);
    pulse_start();
    wait_adv(a0 + 1, 200, "resend_adv");
    @(negedge clk);
    chk("resend_addr", bus.addr, 1);
    chk("resend_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
